cdb_wb_arbiter: RTL and testbench
=================================

// Module: cdb_wb_arbiter
// PURPOSE
//   Collects writeback results from SRC_COUNT execution units (ALU/MUL/DIV/LSU), buffers
//   each in a small per-source FIFO, and round-robin arbitrates them onto CDB_COUNT common
//   data bus ports. Sits directly upstream of the issue queues' wakeup inputs
//   (wkup_valid_i/wkup_rid_i/wkup_data_i) and of the ROB writeback port.
// PARAMETERS
//   SRC_COUNT   4   number of execution-unit result sources
//   CDB_COUNT   2   number of CDB broadcast ports per cycle
//   FIFO_DEPTH  2   entries per source FIFO (power of 2, >=2)
//   ROB_ID_W    6   rob_id width
//   DATA_W      32  result data width
// PORTS
//   clk          in   1                     clock
//   rst_n        in   1                     synchronous, active-low reset
//   flush        in   1                     pipeline flush (mispredict/exception)
//   src_valid_i  in   SRC_COUNT             source i presents a result
//   src_rid_i    in   SRC_COUNT*ROB_ID_W    destination rob_id per source
//   src_data_i   in   SRC_COUNT*DATA_W      result data per source
//   src_ready_o  out  SRC_COUNT             source i FIFO can accept (not full)
//   cdb_valid_o  out  CDB_COUNT             CDB port k carries a result this cycle
//   cdb_rid_o    out  CDB_COUNT*ROB_ID_W    rob_id on port k
//   cdb_data_o   out  CDB_COUNT*DATA_W      data on port k
// BEHAVIOUR
//   Reset/flush (sync, same effect): all FIFOs emptied, counts=0, rr_q=0, cdb_valid_o=0,
//     cdb_rid_o/cdb_data_o=0, src_ready_o=all 1 from the next cycle. src_valid_i ignored
//     in a flush cycle. flush has no further effect on state beyond this.
//   Enqueue: push FIFO i at edge when src_valid_i[i] & src_ready_o[i]. src_valid_i with
//     ready low is dropped by this block; sources hold until ready (valid/ready handshake).
//   src_ready_o[i] = (count_q[i] != FIFO_DEPTH), from registered count only; a same-cycle
//     pop does not raise ready. Push to full FIFO is therefore impossible.
//   Arbitration (comb, on FIFO heads): scan sources starting at rr_q, wrapping mod
//     SRC_COUNT; first non-empty -> port 0, next non-empty -> port 1, ... up to CDB_COUNT.
//     Ungranted ports carry valid=0. Granted heads pop at the same edge.
//   Outputs registered: cdb_* load grants at the edge; each result appears for exactly one
//     cycle. Latency: push at edge E -> cdb_valid_o high in the cycle after edge E+1.
//     No backpressure from CDB; every grant broadcasts unconditionally.
//   rr_q update: if >=1 grant, rr_q <= (last granted index + 1) mod SRC_COUNT; else hold.
//   Counts: push&pop same edge -> count unchanged; FIFO pointers wrap mod FIFO_DEPTH.
//   Ordering: per-source FIFO order preserved; no ordering guarantee across sources.
//   Fairness: a non-empty head is granted within ceil(SRC_COUNT/CDB_COUNT) cycles.
//   Data is passed through unmodified; rob_id not checked for duplicates.
// TESTING
//   Reset: hold rst_n=0 2 cycles -> cdb_valid_o=00, src_ready_o=1111, rr_q=0.
//   Single: src2 pushes rid=5,data=0xDEADBEEF at edge 0 -> after edge 1 cdb_valid_o=01,
//     cdb_rid_o[0]=5, cdb_data_o[0]=0xDEADBEEF for one cycle, then 00.
//   All four push rids 1..4 same edge, rr_q=0 -> next broadcast ports (0,1)=rid1,rid2;
//     following cycle rid3,rid4; rr_q returns to 0; then cdb_valid_o=00.
//   Saturation: all 4 sources valid every cycle 20 cycles, distinct rids -> ready drops on
//     some sources, 2 results/cycle steady, no loss/duplication, per-source order kept.
//   Flush: 3 FIFOs non-empty, assert flush 1 cycle -> next cycle cdb_valid_o=00, ready=1111,
//     pending rids never broadcast.
//   Push+pop: src0 count=1, pushes while head granted -> count stays 1, ready stays 1.

Source files
------------

// File: rtl/cdb_wb_arbiter.sv
// cdb_wb_arbiter
// Buffers writeback results from several execution units in small per-source
// FIFOs. Each cycle it grants up to CDB_COUNT non-empty FIFO heads onto the
// common data bus. Grants use a rotating-priority scan that starts at rr_r.
// CDB outputs are registered, and each result is broadcast for exactly one cycle.
module cdb_wb_arbiter #(
    parameter int SRC_COUNT  = 4,
    parameter int CDB_COUNT  = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int ROB_ID_W   = 6,
    parameter int DATA_W     = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            flush,
    input  logic [SRC_COUNT-1:0]            src_valid_i,
    input  logic [SRC_COUNT*ROB_ID_W-1:0]   src_rid_i,
    input  logic [SRC_COUNT*DATA_W-1:0]     src_data_i,
    output logic [SRC_COUNT-1:0]            src_ready_o,
    output logic [CDB_COUNT-1:0]            cdb_valid_o,
    output logic [CDB_COUNT*ROB_ID_W-1:0]   cdb_rid_o,
    output logic [CDB_COUNT*DATA_W-1:0]     cdb_data_o
);

    localparam int SRC_W  = (SRC_COUNT > 1) ? $clog2(SRC_COUNT) : 1;
    localparam int PORT_W = (CDB_COUNT > 1) ? $clog2(CDB_COUNT) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [PORT_W:0]   GNT_MAX  = (PORT_W + 1)'(CDB_COUNT);
    localparam logic [PORT_W:0]   GNT_ONE  = (PORT_W + 1)'(1);

    // FIFO storage and bookkeeping
    logic [ROB_ID_W-1:0] fifo_rid_r  [SRC_COUNT][FIFO_DEPTH];
    logic [DATA_W-1:0]   fifo_data_r [SRC_COUNT][FIFO_DEPTH];
    logic [PTR_W-1:0]    rd_ptr_r    [SRC_COUNT];
    logic [PTR_W-1:0]    wr_ptr_r    [SRC_COUNT];
    logic [CNT_W-1:0]    count_r     [SRC_COUNT];
    logic [CNT_W-1:0]    count_next_s[SRC_COUNT];
    logic [SRC_COUNT-1:0] ready_r;
    logic [SRC_COUNT-1:0] push_s;
    logic [SRC_COUNT-1:0] grant_s;

    // Arbitration
    logic [SRC_W-1:0]    rr_r;
    logic [SRC_W-1:0]    rr_next_s;
    logic [SRC_W-1:0]    scan_idx_s;
    logic [SRC_W-1:0]    last_idx_s;
    logic [PORT_W:0]     gnt_cnt_s;
    logic [CDB_COUNT-1:0] port_vld_s;
    logic [SRC_W-1:0]    port_src_s [CDB_COUNT];

    // Head-of-FIFO views
    logic [ROB_ID_W-1:0] head_rid_s  [SRC_COUNT];
    logic [DATA_W-1:0]   head_data_s [SRC_COUNT];

    // Registered CDB outputs
    logic [CDB_COUNT-1:0]          cdb_valid_r;
    logic [CDB_COUNT*ROB_ID_W-1:0] cdb_rid_r;
    logic [CDB_COUNT*DATA_W-1:0]   cdb_data_r;

    assign src_ready_o = ready_r;
    assign cdb_valid_o = cdb_valid_r;
    assign cdb_rid_o   = cdb_rid_r;
    assign cdb_data_o  = cdb_data_r;

    // Expose the oldest entry of every source FIFO to the arbiter
    always_comb begin
        for (int i = 0; i < SRC_COUNT; i++) begin
            head_rid_s[i]  = fifo_rid_r[i][rd_ptr_r[i]];
            head_data_s[i] = fifo_data_r[i][rd_ptr_r[i]];
        end
    end

    // Accept a push only when the registered occupancy leaves room; derive next occupancy
    always_comb begin
        for (int i = 0; i < SRC_COUNT; i++) begin
            push_s[i] = src_valid_i[i] & ready_r[i];
            case ({push_s[i], grant_s[i]})
                2'b10:   count_next_s[i] = count_r[i] + CNT_ONE;
                2'b01:   count_next_s[i] = count_r[i] - CNT_ONE;
                default: count_next_s[i] = count_r[i];
            endcase
        end
    end

    // Rotating-priority scan from rr_r: successive non-empty heads fill ports 0,1,...
    always_comb begin
        grant_s    = '0;
        port_vld_s = '0;
        gnt_cnt_s  = '0;
        last_idx_s = rr_r;
        scan_idx_s = rr_r;
        for (int k = 0; k < CDB_COUNT; k++) begin
            port_src_s[k] = '0;
        end
        for (int k = 0; k < SRC_COUNT; k++) begin
            scan_idx_s = SRC_W'((int'(rr_r) + k) % SRC_COUNT);
            if ((count_r[scan_idx_s] != '0) && (gnt_cnt_s < GNT_MAX)) begin
                grant_s[scan_idx_s]                 = 1'b1;
                port_vld_s[gnt_cnt_s[PORT_W-1:0]]   = 1'b1;
                port_src_s[gnt_cnt_s[PORT_W-1:0]]   = scan_idx_s;
                last_idx_s                          = scan_idx_s;
                gnt_cnt_s                           = gnt_cnt_s + GNT_ONE;
            end else begin
                gnt_cnt_s = gnt_cnt_s;
            end
        end
        // Priority moves past the last winner so every source is reached in turn
        if (gnt_cnt_s != '0) begin
            rr_next_s = SRC_W'((int'(last_idx_s) + 1) % SRC_COUNT);
        end else begin
            rr_next_s = rr_r;
        end
    end

    // Sequential update: FIFOs, priority pointer and broadcast registers; reset and flush act alike
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < SRC_COUNT; i++) begin
                rd_ptr_r[i] <= '0;
                wr_ptr_r[i] <= '0;
                count_r[i]  <= '0;
            end
            ready_r     <= '1;
            rr_r        <= '0;
            cdb_valid_r <= '0;
            cdb_rid_r   <= '0;
            cdb_data_r  <= '0;
        end else begin
            for (int i = 0; i < SRC_COUNT; i++) begin
                if (push_s[i]) begin
                    fifo_rid_r[i][wr_ptr_r[i]]  <= src_rid_i[i*ROB_ID_W +: ROB_ID_W];
                    fifo_data_r[i][wr_ptr_r[i]] <= src_data_i[i*DATA_W +: DATA_W];
                    wr_ptr_r[i]                 <= wr_ptr_r[i] + PTR_ONE;
                end
                if (grant_s[i]) begin
                    rd_ptr_r[i] <= rd_ptr_r[i] + PTR_ONE;
                end
                count_r[i] <= count_next_s[i];
                ready_r[i] <= (count_next_s[i] != CNT_FULL);
            end
            rr_r <= rr_next_s;
            for (int k = 0; k < CDB_COUNT; k++) begin
                cdb_valid_r[k] <= port_vld_s[k];
                if (port_vld_s[k]) begin
                    cdb_rid_r[k*ROB_ID_W +: ROB_ID_W] <= head_rid_s[port_src_s[k]];
                    cdb_data_r[k*DATA_W +: DATA_W]    <= head_data_s[port_src_s[k]];
                end else begin
                    cdb_rid_r[k*ROB_ID_W +: ROB_ID_W] <= '0;
                    cdb_data_r[k*DATA_W +: DATA_W]    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// tb_cdb_wb_arbiter
// The bench keeps a reference model built from per-source queues and a priority
// index. On each clock edge it predicts the next broadcast and ready state. It
// pushes that prediction into a scoreboard queue, and a negedge monitor pops the
// queue and compares the prediction against the DUT.
module tb_cdb_wb_arbiter;

    localparam int SRC   = 4;
    localparam int CDB   = 2;
    localparam int DEPTH = 2;
    localparam int RW    = 6;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                flush;
    logic [SRC-1:0]      src_valid_i;
    logic [SRC*RW-1:0]   src_rid_i;
    logic [SRC*DW-1:0]   src_data_i;
    logic [SRC-1:0]      src_ready_o;
    logic [CDB-1:0]      cdb_valid_o;
    logic [CDB*RW-1:0]   cdb_rid_o;
    logic [CDB*DW-1:0]   cdb_data_o;

    always #5 clk = ~clk;

    cdb_wb_arbiter #(
        .SRC_COUNT (SRC),
        .CDB_COUNT (CDB),
        .FIFO_DEPTH(DEPTH),
        .ROB_ID_W  (RW),
        .DATA_W    (DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .src_valid_i(src_valid_i),
        .src_rid_i  (src_rid_i),
        .src_data_i (src_data_i),
        .src_ready_o(src_ready_o),
        .cdb_valid_o(cdb_valid_o),
        .cdb_rid_o  (cdb_rid_o),
        .cdb_data_o (cdb_data_o)
    );

    typedef struct packed {
        logic [RW-1:0] rid;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct {
        logic [CDB-1:0]    vld;
        logic [CDB*RW-1:0] rid;
        logic [CDB*DW-1:0] data;
        logic [SRC-1:0]    rdy;
        bit                zero;
    } exp_t;

    int   vectors     = 0;
    int   miscompares = 0;
    exp_t exp_q[$];
    exp_t me;

    // Reference model state
    ent_t mq[SRC][$];
    int   mrr;

    // Source drivers: a valid is held until the model sees it accepted
    logic           drv_valid[SRC];
    logic [RW-1:0]  drv_rid[SRC];
    logic [DW-1:0]  drv_data[SRC];
    logic [RW-1:0]  rid_ctr;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, queue the prediction
    task automatic cycle(input logic fl);
        exp_t e;
        ent_t ent;
        int   n;
        int   last;
        int   idx;
        bit   acc[SRC];
        flush = fl;
        for (int i = 0; i < SRC; i++) begin
            src_valid_i[i]            = drv_valid[i];
            src_rid_i[i*RW +: RW]     = drv_rid[i];
            src_data_i[i*DW +: DW]    = drv_data[i];
        end
        @(posedge clk);
        e.vld  = '0;
        e.rid  = '0;
        e.data = '0;
        e.rdy  = '1;
        e.zero = 1'b0;
        for (int i = 0; i < SRC; i++) acc[i] = 1'b0;
        if (!rst_n || fl) begin
            for (int i = 0; i < SRC; i++) mq[i].delete();
            mrr    = 0;
            e.zero = 1'b1;
        end else begin
            for (int i = 0; i < SRC; i++) acc[i] = drv_valid[i] && (mq[i].size() != DEPTH);
            n    = 0;
            last = mrr;
            for (int k = 0; k < SRC; k++) begin
                idx = (mrr + k) % SRC;
                if (mq[idx].size() > 0 && n < CDB) begin
                    ent = mq[idx].pop_front();
                    e.vld[n]           = 1'b1;
                    e.rid[n*RW +: RW]  = ent.rid;
                    e.data[n*DW +: DW] = ent.data;
                    n++;
                    last = idx;
                end
            end
            if (n > 0) mrr = (last + 1) % SRC;
            for (int i = 0; i < SRC; i++) begin
                if (acc[i]) begin
                    ent.rid  = drv_rid[i];
                    ent.data = drv_data[i];
                    mq[i].push_back(ent);
                end
                e.rdy[i] = (mq[i].size() != DEPTH);
            end
        end
        exp_q.push_back(e);
        for (int i = 0; i < SRC; i++) if (acc[i]) drv_valid[i] = 1'b0;
        #1;
    endtask

    task automatic load(input int src, input logic [RW-1:0] rid, input logic [DW-1:0] data);
        drv_valid[src] = 1'b1;
        drv_rid[src]   = rid;
        drv_data[src]  = data;
    endtask

    task automatic idle_all();
        for (int i = 0; i < SRC; i++) drv_valid[i] = 1'b0;
    endtask

    // Scoreboard monitor: compares each queued prediction in the cycle it applies to
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            check("cdb_valid", DW'(cdb_valid_o), DW'(me.vld));
            check("src_ready", DW'(src_ready_o), DW'(me.rdy));
            for (int k = 0; k < CDB; k++) begin
                if (me.vld[k] || me.zero) begin
                    check("cdb_rid", DW'(cdb_rid_o[k*RW +: RW]), DW'(me.rid[k*RW +: RW]));
                    check("cdb_data", cdb_data_o[k*DW +: DW], me.data[k*DW +: DW]);
                end
            end
        end
    end

    initial begin
        int guard;
        rst_n       = 1'b0;
        flush       = 1'b0;
        src_valid_i = '0;
        src_rid_i   = '0;
        src_data_i  = '0;
        rid_ctr     = 6'd0;
        mrr         = 0;
        for (int i = 0; i < SRC; i++) begin
            drv_valid[i] = 1'b0;
            drv_rid[i]   = '0;
            drv_data[i]  = '0;
        end
        #2;

        // Reset held two cycles
        cycle(1'b0);
        cycle(1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_valid", DW'(cdb_valid_o), 32'h0000_0000);
        check("reset_ready", DW'(src_ready_o), 32'h0000_000F);

        // Single result from source 2
        load(2, 6'd5, 32'hDEAD_BEEF);
        cycle(1'b0);
        cycle(1'b0);
        @(negedge clk);
        check("single_valid", DW'(cdb_valid_o), 32'h0000_0001);
        check("single_rid", DW'(cdb_rid_o[RW-1:0]), 32'h0000_0005);
        check("single_data", cdb_data_o[DW-1:0], 32'hDEAD_BEEF);
        cycle(1'b0);
        @(negedge clk);
        check("single_gone", DW'(cdb_valid_o), 32'h0000_0000);

        // All four at once from a freshly reset priority pointer
        rst_n = 1'b0;
        cycle(1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < SRC; i++) load(i, RW'(i + 1), $urandom);
        cycle(1'b0);
        cycle(1'b0);
        @(negedge clk);
        check("all4_first_p0", DW'(cdb_rid_o[0 +: RW]), 32'h0000_0001);
        check("all4_first_p1", DW'(cdb_rid_o[RW +: RW]), 32'h0000_0002);
        cycle(1'b0);
        @(negedge clk);
        check("all4_second_p0", DW'(cdb_rid_o[0 +: RW]), 32'h0000_0003);
        check("all4_second_p1", DW'(cdb_rid_o[RW +: RW]), 32'h0000_0004);
        cycle(1'b0);
        @(negedge clk);
        check("all4_drained", DW'(cdb_valid_o), 32'h0000_0000);

        // Flush with three FIFOs occupied
        for (int i = 0; i < 3; i++) load(i, RW'(20 + i), $urandom);
        cycle(1'b0);
        cycle(1'b1);
        idle_all();
        @(negedge clk);
        check("flush_valid", DW'(cdb_valid_o), 32'h0000_0000);
        check("flush_ready", DW'(src_ready_o), 32'h0000_000F);
        cycle(1'b0);
        cycle(1'b0);
        @(negedge clk);
        check("flush_no_leak", DW'(cdb_valid_o), 32'h0000_0000);

        // Push while the single queued head of source 0 is being granted
        load(0, 6'd10, 32'h1111_0000);
        cycle(1'b0);
        load(0, 6'd11, 32'h2222_0000);
        cycle(1'b0);
        @(negedge clk);
        check("pushpop_ready", DW'(src_ready_o[0]), 32'h0000_0001);
        check("pushpop_rid", DW'(cdb_rid_o[0 +: RW]), 32'h0000_000A);
        cycle(1'b0);
        @(negedge clk);
        check("pushpop_next_rid", DW'(cdb_rid_o[0 +: RW]), 32'h0000_000B);
        cycle(1'b0);

        // Saturation: every source offers a result every cycle
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < SRC; i++) begin
                if (!drv_valid[i]) begin
                    rid_ctr = rid_ctr + 6'd1;
                    load(i, rid_ctr, $urandom);
                end
            end
            cycle(1'b0);
        end

        // Random traffic with occasional flushes
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < SRC; i++) begin
                if (!drv_valid[i] && ($urandom_range(0, 1) == 0)) begin
                    rid_ctr = rid_ctr + 6'd1;
                    load(i, rid_ctr, $urandom);
                end
            end
            cycle(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0);
        end

        // Drain
        idle_all();
        for (int c = 0; c < 8; c++) cycle(1'b0);
        @(negedge clk);
        #1;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("scoreboard_drained", DW'(exp_q.size()), 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
